// File: rtl/mem_arbiter_pkg.sv
// Types shared by the memory arbiter and its tag table; pulls bus encodings from sys_defs.
// No logic, no latency; no flow control.
package mem_arbiter_pkg;
`include "sys_defs.svh"

    localparam int XLEN_W   = `XLEN;
    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 16;
    localparam int CNT_W    = 5;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
    } owner_entry_t;

endpackage

// File: rtl/mem_tag_table.sv
// Tag-indexed owner table: combinational lookup of the pre-edge entry, write-after-clear at the edge,
// popcount of the registered entries. Tag 0 is never stored; no backpressure.
import mem_arbiter_pkg::*;

module mem_tag_table (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  MEM_OWNER         wr_owner_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output MEM_OWNER         rd_owner_o,
    output logic [CNT_W-1:0] cnt_o
);

    owner_entry_t [NUM_TAGS-1:0] owner_q, owner_d;

    assign rd_hit_o   = (rd_tag_i != '0) && owner_q[rd_tag_i].valid;
    assign rd_owner_o = owner_q[rd_tag_i].owner;

    // A return and a new grant on the same tag: the clear is applied first so the new entry survives.
    always_comb begin
        owner_d = owner_q;
        if (rd_hit_o) begin
            owner_d[rd_tag_i].valid = 1'b0;
        end
        if (wr_en_i && (wr_tag_i != '0)) begin
            owner_d[wr_tag_i].valid = 1'b1;
            owner_d[wr_tag_i].owner = wr_owner_i;
        end
        owner_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            cnt_o = cnt_o + {{(CNT_W-1){1'b0}}, owner_q[i].valid};
        end
    end

endmodule

// File: rtl/sys_defs.svh
// Shared system definitions: address width and memory bus command encodings.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define XLEN 32

typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
} BUS_COMMAND;

`endif

// File: rtl/mem_arbiter.sv
// icache/dcache memory arbiter: same-cycle grant, tag-owner return routing; rejected requests retry themselves.
// ARB_STARVE_GUARD_EN enables the icache starvation guard (otherwise strict dcache priority).
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        icache_command,
    input  logic [XLEN_W-1:0] icache_addr,
    input  logic [1:0]        dcache_command,
    input  logic [XLEN_W-1:0] dcache_addr,
    input  logic [63:0]       dcache_data,
    input  logic [3:0]        mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [3:0]        mem2proc_tag,
    output logic [1:0]        proc2mem_command,
    output logic [XLEN_W-1:0] proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    output logic [3:0]        icache_response,
    output logic [3:0]        dcache_response,
    output logic [63:0]       icache_data_out,
    output logic [3:0]        icache_tag,
    output logic [63:0]       dcache_data_out,
    output logic [3:0]        dcache_tag,
    output logic [4:0]        outstanding_cnt
);

    logic              ic_req, dc_req;
    logic              grant_ic, grant_dc;
    logic              starve_fire;
    logic [1:0]        gnt_cmd;
    logic [XLEN_W-1:0] gnt_addr;
    logic [63:0]       gnt_data;
    logic              tbl_wr_en;
    logic              rd_hit;
    MEM_OWNER          rd_owner;

    assign ic_req = (icache_command != BUS_NONE);
    assign dc_req = (dcache_command != BUS_NONE);

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;

    assign starve_fire = (int'(starve_q) + 1 >= STARVE_LIMIT);

    always_comb begin
        starve_d = '0;
        if (ic_req && !grant_ic) begin
            starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    assign grant_ic = ic_req && (!dc_req || starve_fire);
    assign grant_dc = dc_req && !grant_ic;

    always_comb begin
        gnt_cmd  = BUS_NONE;
        gnt_addr = '0;
        gnt_data = '0;
        if (grant_dc) begin
            gnt_cmd  = dcache_command;
            gnt_addr = dcache_addr;
            gnt_data = dcache_data;
        end else if (grant_ic) begin
            gnt_cmd  = icache_command;
            gnt_addr = icache_addr;
        end
    end

    // Only accepted loads expect data back; stores and rejections leave the table alone.
    assign tbl_wr_en = (gnt_cmd == BUS_LOAD) && (mem2proc_response != '0);

    mem_tag_table u_tag_table (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (tbl_wr_en),
        .wr_tag_i   (mem2proc_response),
        .wr_owner_i (grant_ic ? OWNER_ICACHE : OWNER_DCACHE),
        .rd_tag_i   (mem2proc_tag),
        .rd_hit_o   (rd_hit),
        .rd_owner_o (rd_owner),
        .cnt_o      (outstanding_cnt)
    );

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        icache_response  = '0;
        dcache_response  = '0;
        icache_data_out  = '0;
        icache_tag       = '0;
        dcache_data_out  = '0;
        dcache_tag       = '0;
        if (reset) begin
            proc2mem_command = gnt_cmd;
            proc2mem_addr    = gnt_addr;
            proc2mem_data    = gnt_data;
            if (grant_ic) icache_response = mem2proc_response;
            if (grant_dc) dcache_response = mem2proc_response;
            if (rd_hit) begin
                if (rd_owner == OWNER_ICACHE) begin
                    icache_data_out = mem2proc_data;
                    icache_tag      = mem2proc_tag;
                end else begin
                    dcache_data_out = mem2proc_data;
                    dcache_tag      = mem2proc_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic against a queue/array model.
import mem_arbiter_pkg::*;

module tb_mem_arbiter;

    localparam int LIM = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        icache_command = '0;
    logic [XLEN_W-1:0] icache_addr = '0;
    logic [1:0]        dcache_command = '0;
    logic [XLEN_W-1:0] dcache_addr = '0;
    logic [63:0]       dcache_data = '0;
    logic [3:0]        mem2proc_response = '0;
    logic [63:0]       mem2proc_data = '0;
    logic [3:0]        mem2proc_tag = '0;
    logic [1:0]        proc2mem_command;
    logic [XLEN_W-1:0] proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [3:0]        icache_response, dcache_response, icache_tag, dcache_tag;
    logic [63:0]       icache_data_out, dcache_data_out;
    logic [4:0]        outstanding_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .icache_response(icache_response), .dcache_response(dcache_response),
        .icache_data_out(icache_data_out), .icache_tag(icache_tag),
        .dcache_data_out(dcache_data_out), .dcache_tag(dcache_tag),
        .outstanding_cnt(outstanding_cnt)
    );

    typedef struct {
        logic [1:0]        cmd;
        logic [XLEN_W-1:0] addr;
        logic [63:0]       data;
        logic [3:0]        ic_resp, dc_resp, ic_tag, dc_tag;
        logic [63:0]       ic_dat, dc_dat;
        logic [4:0]        cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: who owns each outstanding tag, and how long icache has been losing.
    bit   own_valid[16];
    bit   own_is_ic[16];
    int   starve = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst_n, input logic [1:0] icc, input logic [XLEN_W-1:0] ica,
                         input logic [1:0] dcc, input logic [XLEN_W-1:0] dca, input logic [63:0] dcd,
                         input logic [3:0] rsp, input logic [3:0] rtg, input logic [63:0] rdat);
        exp_t e;
        bit   ic_wants, dc_wants, ic_wins, dc_wins;
        int   live;
        @(posedge clk);
        #1;
        reset = rst_n; icache_command = icc; icache_addr = ica;
        dcache_command = dcc; dcache_addr = dca; dcache_data = dcd;
        mem2proc_response = rsp; mem2proc_tag = rtg; mem2proc_data = rdat;

        e = '{cmd: BUS_NONE, addr: '0, data: '0, ic_resp: '0, dc_resp: '0,
              ic_tag: '0, dc_tag: '0, ic_dat: '0, dc_dat: '0, cnt: '0};
        if (!rst_n) begin
            foreach (own_valid[i]) own_valid[i] = 1'b0;
            starve = 0;
        end else begin
            ic_wants = (icc != 2'd0);
            dc_wants = (dcc != 2'd0);
`ifdef ARB_STARVE_GUARD_EN
            ic_wins = ic_wants && (!dc_wants || starve >= LIM - 1);
`else
            ic_wins = ic_wants && !dc_wants;
`endif
            dc_wins = dc_wants && !ic_wins;
            if (dc_wins) begin
                e.cmd = dcc; e.addr = dca; e.data = dcd; e.dc_resp = rsp;
            end else if (ic_wins) begin
                e.cmd = icc; e.addr = ica; e.ic_resp = rsp;
            end
            if (rtg != 0 && own_valid[rtg]) begin
                if (own_is_ic[rtg]) begin e.ic_tag = rtg; e.ic_dat = rdat; end
                else                begin e.dc_tag = rtg; e.dc_dat = rdat; end
            end
            live = 0;
            foreach (own_valid[i]) live += int'(own_valid[i]);
            e.cnt = 5'(live);
            if (rtg != 0) own_valid[rtg] = 1'b0;
            if (e.cmd == BUS_LOAD && rsp != 0) begin
                own_valid[rsp] = 1'b1;
                own_is_ic[rsp] = ic_wins;
            end
            starve = (ic_wants && !ic_wins) ? ((starve < 7) ? starve + 1 : 7) : 0;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input logic [3:0] rtg, input logic [63:0] rdat);
        drive(1'b1, BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, rtg, rdat);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("proc2mem_command", 64'(proc2mem_command), 64'(e.cmd));
                chk("proc2mem_addr",    64'(proc2mem_addr),    64'(e.addr));
                chk("proc2mem_data",    proc2mem_data,         e.data);
                chk("icache_response",  64'(icache_response),  64'(e.ic_resp));
                chk("dcache_response",  64'(dcache_response),  64'(e.dc_resp));
                chk("icache_tag",       64'(icache_tag),       64'(e.ic_tag));
                chk("dcache_tag",       64'(dcache_tag),       64'(e.dc_tag));
                chk("icache_data_out",  icache_data_out,       e.ic_dat);
                chk("dcache_data_out",  dcache_data_out,       e.dc_dat);
                chk("outstanding_cnt",  64'(outstanding_cnt),  64'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        logic [1:0] icc, dcc;
        logic [3:0] rsp, rtg;
        foreach (own_valid[i]) begin own_valid[i] = 1'b0; own_is_ic[i] = 1'b0; end

        // Reset held with live-looking inputs: everything must stay quiet.
        drive(1'b0, BUS_LOAD, 32'h100, BUS_STORE, 32'h200, 64'h55, 4'd3, 4'd3, 64'h1);
        drive(1'b0, BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd0, '0);

        // icache load alone, tag 3.
        drive(1'b1, BUS_LOAD, 32'h100, BUS_NONE, '0, '0, 4'd3, 4'd0, '0);
        idle(4'd0, '0);

        // Both load: dcache wins tag 5, later return routed to dcache only.
        drive(1'b1, BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'h0, 4'd5, 4'd0, '0);
        idle(4'd0, '0);
        idle(4'd5, 64'hDEADBEEF);

        // Store tag 7 is not tracked; its return is dropped.
        drive(1'b1, BUS_NONE, '0, BUS_STORE, 32'h400, 64'h1234_5678_9ABC_DEF0, 4'd7, 4'd0, '0);
        idle(4'd7, 64'hCAFE);

        // Contention run: with the guard icache takes the 4th grant, then must lose again.
        for (int i = 0; i < 6; i++)
            drive(1'b1, BUS_LOAD, 32'h500 + 32'(i), BUS_LOAD, 32'h600 + 32'(i), 64'(i), 4'd0, 4'd0, '0);
        idle(4'd0, '0);

        // Tag 2 returns to dcache in the same cycle icache is granted tag 2.
        drive(1'b1, BUS_NONE, '0, BUS_LOAD, 32'h700, '0, 4'd2, 4'd0, '0);
        drive(1'b1, BUS_LOAD, 32'h800, BUS_NONE, '0, '0, 4'd2, 4'd2, 64'hD00D);
        idle(4'd2, 64'hF00D);
        idle(4'd3, 64'h3333);

        // Three in flight, reset, then a stale return that must vanish.
        drive(1'b1, BUS_LOAD, 32'h900, BUS_NONE, '0, '0, 4'd9, 4'd0, '0);
        drive(1'b1, BUS_NONE, '0, BUS_LOAD, 32'hA00, '0, 4'd10, 4'd0, '0);
        drive(1'b1, BUS_LOAD, 32'hB00, BUS_NONE, '0, '0, 4'd11, 4'd0, '0);
        idle(4'd0, '0);
        drive(1'b0, BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd0, '0);
        idle(4'd9, 64'h9999);
        idle(4'd10, 64'hAAAA);

        // Random traffic, including occasional rejections and resets.
        for (int n = 0; n < 400; n++) begin
            icc = ($urandom_range(0, 2) != 0) ? BUS_LOAD : BUS_NONE;
            case ($urandom_range(0, 3))
                0:       dcc = BUS_NONE;
                1:       dcc = BUS_STORE;
                default: dcc = BUS_LOAD;
            endcase
            rsp = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rtg = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            drive(($urandom_range(0, 99) != 0), icc, XLEN_W'($urandom), dcc, XLEN_W'($urandom),
                  {$urandom, $urandom}, rsp, rtg, {$urandom, $urandom});
        end
        idle(4'd0, '0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
